// File: rtl/vga_timing_pkg.sv
// Timing constants and shared types for the VGA scanout path.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;
    localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
    localparam int HS_END_D   = HS_START_D + H_SYNC_D;
    localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
    localparam int VS_END_D   = VS_START_D + V_SYNC_D;

    // Framebuffer pixel, 4 bits per channel.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Raster control flags that travel alongside the pixel read.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // Blanked, syncs deasserted (both syncs are active-low).
    localparam sync_t SYNC_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    // Outside active video the DAC must see black.
    function automatic pixel_t blank_pixel(input pixel_t p, input logic de);
        return de ? p : '0;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// DEPTH x WIDTH shift register with async active-low clear to rst_val.
// DEPTH=0 collapses to a plain wire.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clock, reset, rst_val};
            assign q = d;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stg;

            // Shift one stage per clock; reset loads the idle pattern everywhere.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    stg <= {DEPTH{rst_val}};
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end

            assign q = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator and framebuffer scanout reader.
// Counters drive the read address; sync/DE are delayed to match the
// framebuffer read latency, then registered together with the pixel.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_D,
    parameter int H_FP         = H_FP_D,
    parameter int H_SYNC       = H_SYNC_D,
    parameter int H_BP         = H_BP_D,
    parameter int V_ACTIVE     = V_ACTIVE_D,
    parameter int V_FP         = V_FP_D,
    parameter int V_SYNC       = V_SYNC_D,
    parameter int V_BP         = V_BP_D,
    parameter int CLK_DIV      = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    input  logic [11:0] vga_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_irq
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE - 1);
    localparam logic [9:0] HS_S    = 10'(HS_START);
    localparam logic [9:0] HS_E    = 10'(HS_END);
    localparam logic [9:0] VS_S    = 10'(VS_START);
    localparam logic [9:0] VS_E    = 10'(VS_END);
    localparam logic [1:0] DIV_L   = 2'(CLK_DIV - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_scanout: H_TOTAL/V_TOTAL exceed 10-bit counters");
        end
        if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
            $error("vga_scanout: CLK_DIV must be 1..4");
        end
        if (READ_LATENCY < 0) begin : g_bad_lat
            $error("vga_scanout: READ_LATENCY must be >= 0");
        end
    endgenerate

    logic [1:0] div;
    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    sync_t      raw;
    sync_t      dly;
    pixel_t     pix_q;
    sync_t      sync_q;
    logic       irq_q;

    // With CLK_DIV=1 the divider never leaves 0, so pix_en stays high.
    assign pix_en = (div == DIV_L);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Pixel-rate divider; held at 0 while scanout is stopped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                div <= '0;
        else if (!enable || pix_en) div <= '0;
        else                       div <= div + 2'd1;
    end

    // Raster counters; stopping scanout parks them at the frame origin.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Vblank interrupt on the step from the last active line into blanking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= enable && pix_en && h_last && (v_cnt == V_ACT_L);
    end

    assign h_addr    = h_cnt;
    assign v_addr    = v_cnt;
    assign frame_irq = irq_q;

    // Undelayed raster flags decoded from the counters.
    always_comb begin
        raw = SYNC_IDLE;
        if (enable) begin
            raw.de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
            raw.hs = !((h_cnt >= HS_S) && (h_cnt < HS_E));
            raw.vs = !((v_cnt >= VS_S) && (v_cnt < VS_E));
        end
    end

    // Match the flags to the framebuffer's read latency.
    vga_delay_line #(
        .DEPTH (READ_LATENCY),
        .WIDTH ($bits(sync_t))
    ) u_dly (
        .clock   (clock),
        .reset   (reset),
        .rst_val (SYNC_IDLE),
        .d       (raw),
        .q       (dly)
    );

    // Pin register: pixel and flags leave the chip on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_q  <= '0;
            sync_q <= SYNC_IDLE;
        end else begin
            pix_q  <= blank_pixel(pixel_t'(vga_data), dly.de);
            sync_q <= dly;
        end
    end

    assign vga_r  = pix_q.r;
    assign vga_g  = pix_q.g;
    assign vga_b  = pix_q.b;
    assign vga_hs = sync_q.hs;
    assign vga_vs = sync_q.vs;
    assign vga_de = sync_q.de;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: default timing (a), reduced timing for
// whole-frame checks (b), and CLK_DIV=2 with a combinational read (c).
module tb_vga_scanout;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

    logic [9:0]  h_a, v_a, h_b, v_b, h_c, v_c;
    logic [11:0] data_a = '0, data_b = '0, data_c;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, vs_a, de_a, irq_a;
    logic        hs_b, vs_b, de_b, irq_b;
    logic        hs_c, vs_c, de_c, irq_c;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Framebuffer models: registered reads for a/b, combinational for c.
    always @(posedge clock) data_a <= {h_a[3:0], v_a[3:0], 4'hA};
    always @(posedge clock) data_b <= {h_b[3:0], v_b[3:0], 4'hA};
    assign data_c = {h_c[3:0], v_c[3:0], 4'hA};

    vga_scanout u_a (
        .clock(clock), .reset(reset), .enable(en_a),
        .h_addr(h_a), .v_addr(v_a), .vga_data(data_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a), .frame_irq(irq_a)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(1), .V_BP(2)
    ) u_b (
        .clock(clock), .reset(reset), .enable(en_b),
        .h_addr(h_b), .v_addr(v_b), .vga_data(data_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b), .frame_irq(irq_b)
    );

    vga_scanout #(.CLK_DIV(2), .READ_LATENCY(0)) u_c (
        .clock(clock), .reset(reset), .enable(en_c),
        .h_addr(h_c), .v_addr(v_c), .vga_data(data_c),
        .vga_r(r_c), .vga_g(g_c), .vga_b(b_c),
        .vga_hs(hs_c), .vga_vs(vs_c), .vga_de(de_c), .frame_irq(irq_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Wait (bounded) until dut a's counters reach h (and v unless any_v).
    task automatic wait_a(input string tag, input logic [9:0] h, input logic [9:0] v,
                          input bit any_v, input int lim);
        int k = 0;
        while (!(h_a == h && (any_v || v_a == v)) && k < lim) begin
            step(1);
            k++;
        end
        chk(tag, {31'd0, (h_a == h && (any_v || v_a == v))}, 32'd1);
    endtask

    initial begin
        int n_hs, n_de, n_vs, n_blk, n_irq;

        // Reset values
        step(2);
        chk("rst_rgb", {r_a, g_a, b_a}, 12'h000);
        chk("rst_hs",  hs_a, 1'b1);
        chk("rst_vs",  vs_a, 1'b1);
        chk("rst_de",  de_a, 1'b0);
        chk("rst_irq", irq_a, 1'b0);
        chk("rst_hv",  {h_a, v_a}, 20'd0);
        chk("rst_hs_c", hs_c, 1'b1);

        reset = 1'b1;
        step(1);
        // Disabled: raster parked at origin
        chk("dis_hv", {h_a, v_a}, 20'd0);
        chk("dis_de", de_a, 1'b0);

        // First pixel arrives two clocks after counters=(0,0)
        en_a = 1'b1;
        step(1);
        chk("first_de_1clk", de_a, 1'b0);
        chk("first_h",       h_a, 10'd1);
        step(1);
        chk("first_de_2clk", de_a, 1'b1);
        chk("first_rgb",     {r_a, g_a, b_a}, 12'h00A);

        // Two full line windows: hsync 96, de 640, never colour while blank
        wait_a("wait_line", 10'd0, 10'd0, 1'b1, 900);
        for (int w = 0; w < 2; w++) begin
            n_hs = 0; n_de = 0; n_vs = 0; n_blk = 0;
            for (int k = 0; k < 800; k++) begin
                step(1);
                if (!hs_a) n_hs++;
                if (de_a)  n_de++;
                if (!vs_a) n_vs++;
                if (!de_a && {r_a, g_a, b_a} != 12'h000) n_blk++;
            end
            chk("line_hs_low", n_hs, 96);
            chk("line_de",     n_de, 640);
            chk("line_vs_low", n_vs, 0);
            chk("line_blank",  n_blk, 0);
        end

        // Pixel (5,3) shows r=5,g=3
        wait_a("wait_5_3", 10'd5, 10'd3, 1'b0, 3000);
        step(2);
        chk("pix_5_3",    {r_a, g_a, b_a}, 12'h53A);
        chk("pix_5_3_de", de_a, 1'b1);

        // Drop enable mid-line
        wait_a("wait_300", 10'd300, 10'd3, 1'b0, 1000);
        en_a = 1'b0;
        step(1);
        chk("drop_hv",  {h_a, v_a}, 20'd0);
        chk("drop_irq", irq_a, 1'b0);
        step(1);
        chk("drop_de",  de_a, 1'b0);
        chk("drop_hs",  hs_a, 1'b1);
        chk("drop_vs",  vs_a, 1'b1);
        chk("drop_rgb", {r_a, g_a, b_a}, 12'h000);
        step(48);
        chk("hold_hv",  {h_a, v_a}, 20'd0);
        chk("hold_de",  de_a, 1'b0);
        en_a = 1'b1;
        step(1);
        chk("rerise_de_1", de_a, 1'b0);
        step(1);
        chk("rerise_de_2", de_a, 1'b1);
        chk("rerise_rgb",  {r_a, g_a, b_a}, 12'h00A);

        // Whole frames on reduced timing (25 x 13, frame = 325 clocks)
        en_b = 1'b1;
        n_hs = 0; n_de = 0; n_vs = 0; n_irq = 0;
        for (int k = 1; k <= 650; k++) begin
            step(1);
            if (!hs_b) n_hs++;
            if (!vs_b) n_vs++;
            if (de_b)  n_de++;
            if (irq_b) begin
                n_irq++;
                chk("irq_pos", {h_b, v_b}, {10'd0, 10'd8});
            end
            if (k == 325) begin
                chk("wrap_hv",  {h_b, v_b}, 20'd0);
                chk("wrap_irq", irq_b, 1'b0);
            end
        end
        chk("frm_irq",    n_irq, 2);
        chk("frm_vs_low", n_vs, 50);
        chk("frm_de",     n_de, 256);
        chk("frm_hs_low", n_hs, 104);

        // CLK_DIV=2, combinational read: one clock of lag, pixels held 2 clocks
        en_c = 1'b1;
        step(1);
        chk("c_h_1",   h_c, 10'd0);
        chk("c_de_1",  de_c, 1'b1);
        chk("c_rgb_1", {r_c, g_c, b_c}, 12'h00A);
        step(1);
        chk("c_h_2",   h_c, 10'd1);
        chk("c_rgb_2", {r_c, g_c, b_c}, 12'h00A);
        step(1);
        chk("c_h_3",   h_c, 10'd1);
        chk("c_rgb_3", {r_c, g_c, b_c}, 12'h10A);
        step(1);
        chk("c_h_4",   h_c, 10'd2);
        chk("c_rgb_4", {r_c, g_c, b_c}, 12'h10A);
        n_hs = 0; n_de = 0;
        for (int k = 0; k < 1600; k++) begin
            step(1);
            if (!hs_c) n_hs++;
            if (de_c)  n_de++;
        end
        chk("c_hs_low", n_hs, 192);
        chk("c_de",     n_de, 1280);

        // Async reset in the middle of hsync
        wait_a("wait_700", 10'd700, 10'd0, 1'b1, 1000);
        chk("pre_rst_hs", hs_a, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_hs",  hs_a, 1'b1);
        chk("arst_vs",  vs_a, 1'b1);
        chk("arst_de",  de_a, 1'b0);
        chk("arst_rgb", {r_a, g_a, b_a}, 12'h000);
        chk("arst_hv",  {h_a, v_a}, 20'd0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("post_rst_h",  h_a, 10'd1);
        chk("post_rst_de", de_a, 1'b0);
        step(1);
        chk("post_rst_de2", de_a, 1'b1);
        chk("post_rst_rgb", {r_a, g_a, b_a}, 12'h00A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
